// File: rtl/floo_axis_noc_bridge_cdt.sv
// rtl/floo_axis_noc_bridge_cdt.sv - credit-flow-controlled multi-channel NoC <-> AXI-Stream bridge
// Beat layout, MSB to LSB: data_vld, cr_vld, cr_idx, ch_idx, flit_data.

module floo_cdt_fifo #(
  parameter int Depth = 4,
  parameter int Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push & ~do_pop)      count <= count + 1'b1;
      else if (do_pop & ~do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module floo_cdt_rr_arb #(
  parameter int N    = 2,
  parameter int IdxW = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic            gnt_vld,
  output logic [IdxW-1:0] gnt_idx
);
  logic [IdxW-1:0] ptr;

  // Lowest requester overall, overridden by the lowest requester at or above ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IdxW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) gnt_idx = IdxW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (adv && gnt_vld) begin
      ptr <= (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

module floo_axis_noc_bridge_cdt #(
  parameter int NumChannels   = 2,
  parameter int FlitDataWidth = 64,
  parameter int RxFifoDepth   = 4,
  parameter int IdxW          = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  parameter int BeatW         = FlitDataWidth + 2 + 2 * IdxW
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumChannels-1:0]               noc_in_valid_i,
  output logic [NumChannels-1:0]               noc_in_ready_o,
  input  logic [NumChannels*FlitDataWidth-1:0] noc_in_data_i,
  output logic [NumChannels-1:0]               noc_out_valid_o,
  input  logic [NumChannels-1:0]               noc_out_ready_i,
  output logic [NumChannels*FlitDataWidth-1:0] noc_out_data_o,
  output logic                                 axis_out_tvalid_o,
  input  logic                                 axis_out_tready_i,
  output logic [BeatW-1:0]                     axis_out_tdata_o,
  input  logic                                 axis_in_tvalid_i,
  output logic                                 axis_in_tready_o,
  input  logic [BeatW-1:0]                     axis_in_tdata_i,
  output logic                                 err_o
);
  localparam int CntW       = $clog2(RxFifoDepth + 1);
  localparam int ChLo       = FlitDataWidth;
  localparam int CrLo       = FlitDataWidth + IdxW;
  localparam int CrVldBit   = FlitDataWidth + 2 * IdxW;
  localparam int DataVldBit = CrVldBit + 1;

  logic [CntW-1:0]          credit [NumChannels];
  logic [CntW-1:0]          pend   [NumChannels];
  logic                     tx_vld;
  logic [BeatW-1:0]         tx_data;
  logic [BeatW-1:0]         next_beat;
  logic                     load;
  logic [NumChannels-1:0]   eligible;
  logic [NumChannels-1:0]   pend_req;
  logic                     data_gnt_vld;
  logic                     cr_gnt_vld;
  logic [IdxW-1:0]          data_gnt;
  logic [IdxW-1:0]          cr_gnt;
  logic                     data_take;
  logic                     cr_take;
  logic [FlitDataWidth-1:0] gnt_flit;
  logic                     err;

  logic                     in_fire;
  logic                     in_dvld;
  logic                     in_cvld;
  logic [IdxW-1:0]          in_ch;
  logic [IdxW-1:0]          in_cr;
  logic                     in_ch_ok;
  logic                     drop;
  logic [NumChannels-1:0]   fifo_push;
  logic [NumChannels-1:0]   fifo_pop;
  logic [NumChannels-1:0]   fifo_empty;
  logic [NumChannels-1:0]   fifo_full;
  logic [NumChannels-1:0]   credit_inc;
  logic [NumChannels-1:0]   credit_dec;
  logic [NumChannels-1:0]   pend_dec;
  logic                     credit_ovf;

  assign load              = ~tx_vld | axis_out_tready_i;
  assign data_take         = load & data_gnt_vld & ~rst_i;
  assign cr_take           = load & cr_gnt_vld & ~rst_i;
  assign axis_out_tvalid_o = tx_vld;
  assign axis_out_tdata_o  = tx_data;
  assign err_o             = err;

  always_comb begin
    eligible = '0;
    pend_req = '0;
    for (int c = 0; c < NumChannels; c++) begin
      eligible[c] = noc_in_valid_i[c] & (credit[c] != '0);
      pend_req[c] = (pend[c] != '0);
    end
  end

  floo_cdt_rr_arb #(.N(NumChannels), .IdxW(IdxW)) i_data_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (eligible),
    .adv     (data_take),
    .gnt_vld (data_gnt_vld),
    .gnt_idx (data_gnt)
  );

  floo_cdt_rr_arb #(.N(NumChannels), .IdxW(IdxW)) i_cr_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (pend_req),
    .adv     (cr_take),
    .gnt_vld (cr_gnt_vld),
    .gnt_idx (cr_gnt)
  );

  always_comb begin
    noc_in_ready_o = '0;
    gnt_flit       = '0;
    for (int c = 0; c < NumChannels; c++) begin
      noc_in_ready_o[c] = data_take && (data_gnt == IdxW'(c));
      if (data_gnt == IdxW'(c)) gnt_flit = noc_in_data_i[c*FlitDataWidth +: FlitDataWidth];
    end
  end

  always_comb begin
    next_beat             = '0;
    next_beat[DataVldBit] = data_gnt_vld;
    next_beat[CrVldBit]   = cr_gnt_vld;
    if (cr_gnt_vld) next_beat[CrLo +: IdxW] = cr_gnt;
    if (data_gnt_vld) begin
      next_beat[ChLo +: IdxW]           = data_gnt;
      next_beat[FlitDataWidth-1:0]      = gnt_flit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_vld  <= 1'b0;
      tx_data <= '0;
    end else if (load) begin
      tx_vld  <= data_gnt_vld | cr_gnt_vld;
      tx_data <= next_beat;
    end
  end

  // RX decode; the link is never backpressured because credits guarantee space.
  assign axis_in_tready_o = ~rst_i;
  assign in_fire          = axis_in_tvalid_i & ~rst_i;
  assign in_dvld          = axis_in_tdata_i[DataVldBit];
  assign in_cvld          = axis_in_tdata_i[CrVldBit];
  assign in_ch            = axis_in_tdata_i[ChLo +: IdxW];
  assign in_cr            = axis_in_tdata_i[CrLo +: IdxW];
  assign noc_out_valid_o  = ~fifo_empty & {NumChannels{~rst_i}};
  assign fifo_pop         = noc_out_valid_o & noc_out_ready_i;

  always_comb begin
    in_ch_ok  = 1'b0;
    fifo_push = '0;
    drop      = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (in_ch == IdxW'(c)) in_ch_ok = 1'b1;
    end
    if (in_fire && in_dvld) begin
      drop = ~in_ch_ok;
      for (int c = 0; c < NumChannels; c++) begin
        if (in_ch == IdxW'(c)) begin
          if (fifo_full[c] && !fifo_pop[c]) drop = 1'b1;
          else                              fifo_push[c] = 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_rx
    floo_cdt_fifo #(.Depth(RxFifoDepth), .Width(FlitDataWidth)) i_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (fifo_push[c]),
      .wdata (axis_in_tdata_i[FlitDataWidth-1:0]),
      .pop   (fifo_pop[c]),
      .rdata (noc_out_data_o[c*FlitDataWidth +: FlitDataWidth]),
      .empty (fifo_empty[c]),
      .full  (fifo_full[c])
    );
  end

  always_comb begin
    credit_inc = '0;
    credit_dec = '0;
    pend_dec   = '0;
    credit_ovf = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      credit_inc[c] = in_fire && in_cvld && (in_cr == IdxW'(c));
      credit_dec[c] = data_take && (data_gnt == IdxW'(c));
      pend_dec[c]   = cr_take && (cr_gnt == IdxW'(c));
      if (credit_inc[c] && !credit_dec[c] && (credit[c] == CntW'(RxFifoDepth))) credit_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumChannels; c++) begin
        credit[c] <= CntW'(RxFifoDepth);
        pend[c]   <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (credit_inc[c] && !credit_dec[c]) begin
          if (credit[c] != CntW'(RxFifoDepth)) credit[c] <= credit[c] + 1'b1;
        end else if (credit_dec[c] && !credit_inc[c]) begin
          credit[c] <= credit[c] - 1'b1;
        end
        if (fifo_pop[c] && !pend_dec[c])      pend[c] <= pend[c] + 1'b1;
        else if (pend_dec[c] && !fifo_pop[c]) pend[c] <= pend[c] - 1'b1;
      end
      if (drop || credit_ovf) err <= 1'b1;
    end
  end
endmodule

// File: doc/floo_axis_noc_bridge_cdt.md
Name: floo_axis_noc_bridge_cdt

Overview:
- Multi-channel, credit-flow-controlled bridge between NumChannels NoC flit channels and one AXI-Stream link pair, generalising the 2-channel req/rsp bridge.
- NoC→AXIS: round-robin arbitration over channels holding credits, with a registered output beat.
- AXIS→NoC: per-channel RX FIFOs, so one stalled NoC channel never blocks the link; credits are piggybacked on outgoing beats.
- Two instances, one at each end of the serial link, form a lossless, deadlock-free multi-VC link.

Parameters:
- NumChannels, 2, number of NoC flit channels (>=1).
- FlitDataWidth, 64, flit payload bits per channel.
- RxFifoDepth, 4, per-channel RX FIFO depth (>=1); also the initial credit count toward the peer.
- IdxW, max(1,$clog2(NumChannels)), derived: channel index width.
- BeatW, FlitDataWidth+2+2*IdxW, derived: AXIS tdata width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- noc_in_valid_i  in  NumChannels  flit valid per channel, toward the link.
- noc_in_ready_o  out  NumChannels  flit accepted.
- noc_in_data_i  in  NumChannels*FlitDataWidth  flit payloads; channel c at slice c.
- noc_out_valid_o  out  NumChannels  received flit valid per channel.
- noc_out_ready_i  in  NumChannels  NoC accepts received flit.
- noc_out_data_o  out  NumChannels*FlitDataWidth  received payloads.
- axis_out_tvalid_o  out  1  outgoing beat valid.
- axis_out_tready_i  in  1  peer accepts beat.
- axis_out_tdata_o  out  BeatW  outgoing beat.
- axis_in_tvalid_i  in  1  incoming beat valid.
- axis_in_tready_o  out  1  bridge accepts beat.
- axis_in_tdata_i  in  BeatW  incoming beat.
- err_o  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Beat format, MSB→LSB: data_vld, cr_vld, cr_idx[IdxW], ch_idx[IdxW], flit_data[FlitDataWidth]. Unused fields are driven to 0.
- Reset values (synchronous; asserting rst_i mid-operation aborts everything in the next cycle):
  - axis_out_tvalid_o=0, tdata=0, noc_in_ready_o=0, noc_out_valid_o=0, axis_in_tready_o=0, err_o=0.
  - credit[c]=RxFifoDepth, pend[c]=0, all FIFOs empty, both arbiter pointers at channel 0.
- TX output register (1 entry):
  - "load" = register empty OR (tvalid & tready).
  - On load, the register takes a new beat if any channel is eligible or any pend[c]>0; otherwise tvalid drops to 0.
  - While tvalid=1 & tready=0, tdata is held stable.
- TX data arbitration:
  - eligible[c] = noc_in_valid_i[c] & credit[c]>0.
  - A round-robin arbiter picks channel g among eligible channels; data_vld=1, ch_idx=g.
  - noc_in_ready_o[g]=1 only in the load cycle (combinational from load and grant); all other ready bits are 0.
  - The arbiter pointer advances past g only on an accepted flit.
  - Latency from NoC accept to tvalid: 1 cycle.
- TX credit return:
  - An independent round-robin arbiter picks r among pend[r]>0; sets cr_vld=1, cr_idx=r.
  - Credit returns ride on data beats when both exist. If only credits are pending, a credit-only beat is sent (data_vld=0).
- credit[c] update:
  - -1 when a data beat for c is loaded.
  - +1 when an accepted incoming beat has cr_vld & cr_idx=c.
  - Both in the same cycle: unchanged.
  - An increment that would exceed RxFifoDepth: saturate and set err_o.
- pend[c] update (width $clog2(RxFifoDepth+1)):
  - +1 on noc_out_valid_o[c] & noc_out_ready_i[c].
  - -1 when a credit-return beat for c is loaded.
  - Both in the same cycle: unchanged.
- RX path:
  - axis_in_tready_o=1 whenever not in reset. Credits guarantee space, so the link never backpressures.
  - An accepted beat with data_vld=1 pushes flit_data into FIFO[ch_idx].
  - FIFO full, or ch_idx>=NumChannels: the beat is dropped and err_o is set. Any credit field on that beat is still processed.
  - noc_out_valid_o[c] = FIFO[c] non-empty. Data appears the cycle after the push (1-cycle latency). Output is stable until ready.
  - Push and pop on the same FIFO in the same cycle: both occur, and this is legal when full.
  - A beat with data_vld=0 and cr_vld=0 is legal and ignored.
- Ordering: flits of one channel keep their order end to end. No ordering is guaranteed between channels.
- NumChannels=1: IdxW=1, and index fields are always 0.

Test Plan:
- Reset then idle, tready=1 → tvalid=0, credits=4 (RxFifoDepth=4), err_o=0 for 20 cycles.
- Single flit 0xA5 on ch1 with NumChannels=2 → one cycle later tdata has data_vld=1, ch_idx=1, flit=0xA5; noc_in_ready_o[1] high for exactly 1 cycle.
- Both channels valid continuously, tready=1, peer loopback returning credits → beats alternate ch0/ch1; no channel starves; no err.
- Ch0 valid, no credits returned → exactly 4 beats sent, then noc_in_ready_o[0]=0. Inject an incoming credit-only beat (cr_vld=1, cr_idx=0) → exactly 1 more ch0 flit is sent.
- Incoming beats: 4 for ch1 with noc_out_ready_i[1]=0, meanwhile 3 for ch0 with ready=1 → ch0 delivers 3 in order while ch1 holds 4. Release ch1 → 4 credit-return beats for ch1 observed, plus 3 for ch0.
- tready=0 for 10 cycles with tvalid=1 → tdata stable. Fifth ch0 beat while FIFO0 is full → dropped, err_o=1 and stays high. rst_i pulse → all state returns to reset values.
